// File: rtl/note_pkg.sv
// note_pkg: shared note-chart encoding used by the chart recorder and the play logic.
// Holds the 2-bit slot codes, the recorder state enum and the press priority helper.
package note_pkg;

    localparam int SLOT_W = 2;

    localparam logic [SLOT_W-1:0] CODE_REST = 2'b00;
    localparam logic [SLOT_W-1:0] CODE_K1   = 2'b01;
    localparam logic [SLOT_W-1:0] CODE_K2   = 2'b10;
    localparam logic [SLOT_W-1:0] CODE_K0   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_DONE   = 2'd2
    } rec_state_e;

    // Same-cycle presses resolve KEY[1] > KEY[2] > KEY[0]; no press gives REST.
    function automatic logic [SLOT_W-1:0] press_code(input logic [2:0] press);
        logic [SLOT_W-1:0] code;
        code = CODE_REST;
        if (press[1]) begin
            code = CODE_K1;
        end else if (press[2]) begin
            code = CODE_K2;
        end else if (press[0]) begin
            code = CODE_K0;
        end
        return code;
    endfunction

endpackage

// File: rtl/key_edge_sync.sv
// key_edge_sync: 3-lane synchroniser for the active-low board keys followed by a
// falling-edge detector. press_o is a one-cycle, active-high pulse per key press,
// so a held key yields exactly one press.
module key_edge_sync (
    input  logic       clk,
    input  logic       reset_b,
    input  logic [2:0] key_b_i,
    output logic [2:0] press_o
);

    logic [2:0] meta_q;
    logic [2:0] sync_q;
    logic [2:0] prev_q;

    // Two-flop synchroniser plus one cycle of history; reset to released (1) so
    // leaving reset never looks like a press.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            meta_q <= '1;
            sync_q <= '1;
            prev_q <= '1;
        end else begin
            meta_q <= key_b_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign press_o = prev_q & ~sync_q;

endmodule

// File: rtl/note_chart_recorder.sv
// note_chart_recorder: records key presses into a packed 2-bit-per-slot note chart.
// A beat down-counter splits the session into SLOTS slots of BEAT_CYCLES cycles;
// the first press in each slot becomes that slot's code.
// Optional build macro: NOTE_CHART_OVERDUB_EN -- start keeps the chart and commits
// only overwrite slots in which a press was captured.
//
// state     | meaning
// ST_IDLE   | no session; chart holds last contents
// ST_RECORD | session running, beat counter active
// ST_DONE   | last slot committed; outputs hold until next start
module note_chart_recorder
    import note_pkg::*;
#(
    parameter int SLOTS       = 120,
    parameter int BEAT_CYCLES = 5000000
) (
    input  logic                  clk,
    input  logic                  reset_b,
    input  logic                  start,
    input  logic                  abort,
    input  logic [3:0]            KEY,
    output logic [2*SLOTS-1:0]    chart,
    output logic [6:0]            slot_idx,
    output logic                  recording,
    output logic                  beat,
    output logic                  done
);

    localparam int                CNT_W      = $clog2(BEAT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(BEAT_CYCLES - 1);
    localparam logic [6:0]        LAST_SLOT  = 7'(SLOTS - 1);

    rec_state_e             state_q, state_d;
    logic [2*SLOTS-1:0]     chart_q, chart_d;
    logic [6:0]             slot_q, slot_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SLOT_W-1:0]      pend_q, pend_d;
    logic                   pend_vld_q, pend_vld_d;
    logic                   beat_q, beat_d;
    logic                   done_q, done_d;

    logic [2:0]             press;
    logic [SLOT_W-1:0]      edge_code;
    logic [SLOT_W-1:0]      commit_code;
    logic                   commit_hit;
    logic                   slot_wr;
    logic                   unused_key3;

    assign unused_key3 = KEY[3];

    key_edge_sync u_key_edge_sync (
        .clk     (clk),
        .reset_b (reset_b),
        .key_b_i (KEY[2:0]),
        .press_o (press)
    );

    // A pending code wins over a press arriving on the commit edge itself.
    assign edge_code   = press_code(press);
    assign commit_code = pend_vld_q ? pend_q : edge_code;
    assign commit_hit  = pend_vld_q | (|press);

    // Next-state, counter, pending-code and chart update.
    always_comb begin
        state_d    = state_q;
        chart_d    = chart_q;
        slot_d     = slot_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        beat_d     = 1'b0;
        done_d     = 1'b0;
        slot_wr    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start && !abort) begin
                    state_d    = ST_RECORD;
                    slot_d     = '0;
                    cnt_d      = CNT_RELOAD;
                    pend_vld_d = 1'b0;
`ifndef NOTE_CHART_OVERDUB_EN
                    chart_d    = '0;
`endif
                end
            end
            ST_RECORD: begin
                if (abort) begin
                    state_d    = ST_IDLE;
                    pend_vld_d = 1'b0;
                end else if (start) begin
                    slot_d     = '0;
                    cnt_d      = CNT_RELOAD;
                    pend_vld_d = 1'b0;
`ifndef NOTE_CHART_OVERDUB_EN
                    chart_d    = '0;
`endif
                end else if (cnt_q == '0) begin
`ifdef NOTE_CHART_OVERDUB_EN
                    slot_wr    = commit_hit;
`else
                    slot_wr    = 1'b1;
`endif
                    pend_vld_d = 1'b0;
                    cnt_d      = CNT_RELOAD;
                    beat_d     = 1'b1;
                    if (slot_q == LAST_SLOT) begin
                        state_d = ST_DONE;
                        slot_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        slot_d  = slot_q + 7'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (!pend_vld_q && (|press)) begin
                        pend_d     = edge_code;
                        pend_vld_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        for (int k = 0; k < SLOTS; k++) begin
            if (slot_wr && (slot_q == 7'(k))) begin
                chart_d[SLOT_W*k +: SLOT_W] = commit_code;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q    <= ST_IDLE;
            chart_q    <= '0;
            slot_q     <= '0;
            cnt_q      <= '0;
            pend_q     <= CODE_REST;
            pend_vld_q <= 1'b0;
            beat_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            chart_q    <= chart_d;
            slot_q     <= slot_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            beat_q     <= beat_d;
            done_q     <= done_d;
        end
    end

    assign chart     = chart_q;
    assign slot_idx  = slot_q;
    assign recording = (state_q == ST_RECORD);
    assign beat      = beat_q;
    assign done      = done_q;

endmodule

// File: tb/tb_note_chart_recorder.sv
// Bench for note_chart_recorder with SLOTS=4, BEAT_CYCLES=8.
// Reference model: every key fall is logged with the edge at which it is captured
// (fall time + 3 edges); a slot's code is the earliest capture inside its window
// (t+k*B, t+(k+1)*B], ties broken KEY[1] > KEY[2] > KEY[0].
`timescale 1ns/1ps
module tb_note_chart_recorder;

    localparam int SLOTS   = 4;
    localparam int B       = 8;
    localparam int SESSION = SLOTS * B;
    localparam int NO      = -100;

    logic       clk = 1'b0;
    logic       reset_b = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] KEY = 4'hF;
    logic [7:0] chart;
    logic [6:0] slot_idx;
    logic       recording;
    logic       beat;
    logic       done;

    note_chart_recorder #(.SLOTS(SLOTS), .BEAT_CYCLES(B)) dut (
        .clk       (clk),
        .reset_b   (reset_b),
        .start     (start),
        .abort     (abort),
        .KEY       (KEY),
        .chart     (chart),
        .slot_idx  (slot_idx),
        .recording (recording),
        .beat      (beat),
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int beat_cnt = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    logic [7:0] exp_chart = 8'h00;

    typedef struct { int e; int lane; } ev_t;
    ev_t evq[$];

    typedef struct {
        int f0; int r0;
        int f1; int r1;
        int f2; int r2;
        logic [7:0] exp;
    } vec_t;

    vec_t vec[10];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (beat) beat_cnt <= beat_cnt + 1;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_keys(input logic [2:0] v);
        ev_t ev;
        for (int i = 0; i < 3; i++) begin
            if (KEY[i] && !v[i]) begin
                ev.e = cyc + 3;
                ev.lane = i;
                evq.push_back(ev);
            end
        end
        KEY[2:0] = v;
    endtask

    function automatic int lane_rank(input int lane);
        if (lane == 1) return 0;
        if (lane == 2) return 1;
        return 2;
    endfunction

    function automatic logic [1:0] lane_code(input int lane);
        if (lane == 1) return 2'b01;
        if (lane == 2) return 2'b10;
        return 2'b11;
    endfunction

    function automatic logic [1:0] slot_code(input int t, input int k);
        int best_e;
        int best_r;
        logic [1:0] code;
        best_e = 1 << 30;
        best_r = 3;
        code = 2'b00;
        foreach (evq[i]) begin
            if (evq[i].e > t + k*B && evq[i].e <= t + (k+1)*B) begin
                if (evq[i].e < best_e ||
                    (evq[i].e == best_e && lane_rank(evq[i].lane) < best_r)) begin
                    best_e = evq[i].e;
                    best_r = lane_rank(evq[i].lane);
                    code = lane_code(evq[i].lane);
                end
            end
        end
        return code;
    endfunction

    task automatic do_reset();
        set_keys(3'b111);
        step();
        step();
        reset_b = 1'b0;
        step();
        reset_b = 1'b1;
        step();
        evq.delete();
        exp_chart = 8'h00;
    endtask

    task automatic begin_session(output int t);
        start = 1'b1;
        t = cyc + 1;
        step();
        start = 1'b0;
    endtask

    // Drives scheduled key falls/rises, abort and start (offsets relative to t)
    // until the cycle counter reaches end_c.
    task automatic drive_window(input vec_t v, input int t, input int end_c,
                                input int abort_off, input int start_off);
        logic [2:0] kv;
        while (cyc < end_c) begin
            kv = KEY[2:0];
            if (cyc == t + v.f0) kv[0] = 1'b0;
            if (cyc == t + v.r0) kv[0] = 1'b1;
            if (cyc == t + v.f1) kv[1] = 1'b0;
            if (cyc == t + v.r1) kv[1] = 1'b1;
            if (cyc == t + v.f2) kv[2] = 1'b0;
            if (cyc == t + v.r2) kv[2] = 1'b1;
            set_keys(kv);
            abort = (cyc == t + abort_off);
            start = (cyc == t + start_off);
            step();
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    task automatic rand_session(input int idx);
        int t, a_drive, end_c, b0, d0, ncommit;
        bit do_abort;
        logic [2:0] kv;
        logic [1:0] code;
        do_abort = ($urandom_range(0, 2) == 0);
        b0 = beat_cnt;
        d0 = done_cnt;
        begin_session(t);
        a_drive = do_abort ? t + int'($urandom_range(1, SESSION - 2)) : NO;
        end_c = do_abort ? a_drive + 4 : t + SESSION + 3;
        while (cyc < end_c) begin
            kv = KEY[2:0];
            for (int i = 0; i < 3; i++)
                if ($urandom_range(0, 5) == 0) kv[i] = ~kv[i];
            set_keys(kv);
            abort = (cyc == a_drive);
            step();
        end
        abort = 1'b0;
        ncommit = 0;
        for (int k = 0; k < SLOTS; k++) begin
            if (do_abort && (t + (k+1)*B >= a_drive + 1)) begin
`ifndef NOTE_CHART_OVERDUB_EN
                exp_chart[2*k +: 2] = 2'b00;
`endif
            end else begin
                ncommit++;
                code = slot_code(t, k);
`ifdef NOTE_CHART_OVERDUB_EN
                if (code != 2'b00) exp_chart[2*k +: 2] = code;
`else
                exp_chart[2*k +: 2] = code;
`endif
            end
        end
        chk($sformatf("rand%0d chart", idx), 32'(chart), 32'(exp_chart));
        chk($sformatf("rand%0d beats", idx), beat_cnt - b0, ncommit);
        chk($sformatf("rand%0d dones", idx), done_cnt - d0, do_abort ? 0 : 1);
        if (!do_abort) chk($sformatf("rand%0d done_cyc", idx), done_cyc, t + SESSION);
        chk($sformatf("rand%0d recording", idx), 32'(recording), 32'd0);
        for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
            kv = KEY[2:0];
            if ($urandom_range(0, 2) == 0) kv[$urandom_range(0, 2)] ^= 1'b1;
            set_keys(kv);
            step();
        end
    endtask

    initial begin
        int t, t2, b0, d0;
        vec_t v;
        vec_t none;

        vec[0] = '{NO, NO, 1, 3, 17, 19, 8'h21};     // basic session
        vec[1] = '{9, 11, 9, 11, NO, NO, 8'h04};     // K1+K0 same cycle, slot 1
        vec[2] = '{28, 30, NO, NO, 25, 27, 8'h80};   // K2 then K0 in slot 3
        vec[3] = '{0, 20, NO, NO, NO, NO, 8'h03};    // K0 held slots 0..2
        vec[4] = '{5, 7, NO, NO, 14, 16, 8'h23};     // capture on commit edge, nothing pending
        vec[5] = '{NO, NO, 9, 11, 13, 15, 8'h04};    // capture on commit edge with pending: dropped
        vec[6] = '{17, 19, 17, 19, 17, 19, 8'h10};   // all three same cycle
        vec[7] = '{2, 4, NO, NO, 2, 4, 8'h02};       // K2+K0 same cycle
        vec[8] = '{NO, NO, 29, 31, NO, NO, 8'h40};   // capture on the final commit edge
        vec[9] = '{30, 32, NO, NO, NO, NO, 8'h00};   // capture after DONE is ignored
        none = '{NO, NO, NO, NO, NO, NO, 8'h00};

        // reset values
        step();
        chk("reset chart", 32'(chart), 32'd0);
        chk("reset slot_idx", 32'(slot_idx), 32'd0);
        chk("reset recording", 32'(recording), 32'd0);
        chk("reset beat", 32'(beat), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        reset_b = 1'b1;
        step();

        // table-driven sessions, each from a fresh reset
        for (int i = 0; i < 10; i++) begin
            do_reset();
            b0 = beat_cnt;
            d0 = done_cnt;
            begin_session(t);
            chk($sformatf("vec%0d recording", i), 32'(recording), 32'd1);
            drive_window(vec[i], t, t + SESSION + 3, NO, NO);
            chk($sformatf("vec%0d chart", i), 32'(chart), 32'(vec[i].exp));
            chk($sformatf("vec%0d beats", i), beat_cnt - b0, SLOTS);
            chk($sformatf("vec%0d dones", i), done_cnt - d0, 1);
            chk($sformatf("vec%0d done_cyc", i), done_cyc, t + SESSION);
            chk($sformatf("vec%0d slot_idx", i), 32'(slot_idx), 32'd0);
            chk($sformatf("vec%0d recording end", i), 32'(recording), 32'd0);
        end

        // reset asserted mid-RECORD
        do_reset();
        begin_session(t);
        v = none; v.f1 = 1; v.r1 = 3;
        drive_window(v, t, t + 12, NO, NO);
        chk("midrst pre chart", 32'(chart), 32'h01);
        chk("midrst pre slot_idx", 32'(slot_idx), 32'd1);
        chk("midrst pre recording", 32'(recording), 32'd1);
        reset_b = 1'b0;
        #1;
        chk("midrst chart", 32'(chart), 32'd0);
        chk("midrst slot_idx", 32'(slot_idx), 32'd0);
        chk("midrst recording", 32'(recording), 32'd0);
        chk("midrst beat", 32'(beat), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        step();
        reset_b = 1'b1;
        b0 = beat_cnt;
        for (int i = 0; i < 12; i++) step();
        chk("midrst idle recording", 32'(recording), 32'd0);
        chk("midrst idle beats", beat_cnt - b0, 0);

        // abort in slot 2
        do_reset();
        b0 = beat_cnt;
        d0 = done_cnt;
        begin_session(t);
        v = none; v.f1 = 1; v.r1 = 3; v.f0 = 9; v.r0 = 11; v.f2 = 17; v.r2 = 19;
        drive_window(v, t, t + SESSION + 4, 20, NO);
        chk("abort chart", 32'(chart), 32'h0D);
        chk("abort beats", beat_cnt - b0, 2);
        chk("abort dones", done_cnt - d0, 0);
        chk("abort recording", 32'(recording), 32'd0);

        // abort and start together while idle: abort wins
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("abort+start recording", 32'(recording), 32'd0);
        for (int i = 0; i < 10; i++) step();
        chk("abort+start chart", 32'(chart), 32'h0D);

        // start during RECORD restarts the session
        do_reset();
        b0 = beat_cnt;
        d0 = done_cnt;
        begin_session(t);
        v = none; v.f2 = 1; v.r2 = 3;
        drive_window(v, t, t + 13, NO, 12);
        t2 = t + 13;
        v = none; v.f0 = 9; v.r0 = 11;
        drive_window(v, t2, t2 + SESSION + 3, NO, NO);
`ifdef NOTE_CHART_OVERDUB_EN
        chk("restart chart", 32'(chart), 32'h0E);
`else
        chk("restart chart", 32'(chart), 32'h0C);
`endif
        chk("restart beats", beat_cnt - b0, 5);
        chk("restart dones", done_cnt - d0, 1);
        chk("restart done_cyc", done_cyc, t2 + SESSION);

        // second session after a complete one (overdub keeps earlier slots)
        do_reset();
        begin_session(t);
        drive_window(vec[0], t, t + SESSION + 3, NO, NO);
        begin_session(t2);
        v = none; v.f2 = 25; v.r2 = 27;
        drive_window(v, t2, t2 + SESSION + 3, NO, NO);
`ifdef NOTE_CHART_OVERDUB_EN
        chk("second chart", 32'(chart), 32'hA1);
`else
        chk("second chart", 32'(chart), 32'h80);
`endif
        chk("second done_cyc", done_cyc, t2 + SESSION);

        // randomized sessions against the reference model
        do_reset();
        for (int s = 0; s < 25; s++) rand_session(s);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/note_chart_recorder.md
# note_chart_recorder

Records player button presses into a packed note chart for the rhythm game. It is the writer for the 2-bit-per-slot note stream that the play logic consumes, and uses the same encoding and slot packing. A free-running beat timer divides a recording session into fixed-length slots. The first key press in each slot is quantised into that slot's 2-bit code, and `done` pulses when the chart is complete.

## Interface
- `SLOTS`, 120, number of 2-bit slots in the chart (chart width = 2*SLOTS).
- `BEAT_CYCLES`, 5000000, clock cycles per slot; must be ≥ 4.
- `clk` in 1: system clock (CLOCK_50 domain).
- `reset_b` in 1: reset; one clock, asynchronous, active-low.
- `start` in 1: single-cycle request to begin a recording session.
- `abort` in 1: end the session immediately.
- `KEY` in 4: raw board push buttons, active-low, asynchronous. KEY[3] is unused.
- `chart` out 2*SLOTS: packed chart; slot k occupies bits [2k+1:2k].
- `slot_idx` out 7: slot currently being recorded.
- `recording` out 1: high while in RECORD.
- `beat` out 1: one-cycle pulse after each slot commit.
- `done` out 1: one-cycle pulse when the last slot commits.

## Operation
- Codes:
  - REST = 00
  - KEY[1] = 01
  - KEY[2] = 10
  - KEY[0] = 11
- States:
  - IDLE, RECORD and DONE.
  - IDLE/DONE on `start` → RECORD. Chart is cleared to all REST, `slot_idx` is set to 0 and the beat counter is loaded with BEAT_CYCLES-1.
  - RECORD: the beat counter decrements every cycle. At 0 it commits the slot, reloads, and increments `slot_idx`.
  - The commit of slot SLOTS-1 → DONE.
  - RECORD on `abort` → IDLE. Committed slots are kept; the current slot is discarded; no `done`.
  - `abort` and `start` in the same cycle: `abort` wins.
  - `start` while in RECORD restarts the session, clearing the chart.
- Key capture:
  - KEY[2:0] pass through a 2-flop synchroniser followed by falling-edge detection. A held key produces exactly one press.
  - A pending-code register holds the first press seen in the current slot; later presses in that slot are ignored.
  - Same-cycle presses are resolved by priority KEY[1] > KEY[2] > KEY[0].
  - Commit value = pending if valid, else the same-cycle edge code, else REST. Pending clears on every commit.
- Outputs hold their values in DONE until the next `start`.

## Timing
- Reset values: state IDLE, `chart` all 0, `slot_idx` 0, `recording`/`beat`/`done` 0, synchroniser flops 1 (released).
- Press latency: a KEY falling edge before clock edge n is captured at edge n+2.
- Session schedule, for `start` sampled at edge t:
  - `recording` is high from t+1.
  - Slot k commits at edge t+(k+1)*BEAT_CYCLES.
  - `beat` is high in the cycle following each commit.
  - `done` is high for the one cycle following edge t+SLOTS*BEAT_CYCLES, together with the final `beat`.
  - `recording` falls in that same cycle.
- A press captured on a commit edge belongs to the closing slot only if no code is pending for that slot; otherwise it is dropped.
- `slot_idx` wraps to 0 on entry to DONE.
- An asserted `reset_b` mid-session forces all reset values immediately.

## Configuration
- `NOTE_CHART_OVERDUB_EN`
  - Defined (overdub mode):
    - `start` does not clear the chart.
    - A commit writes a slot only when a press was captured; REST slots keep their previous contents.
  - Undefined: every slot is written on commit, and `start` clears the chart.

## Structure
- Shared package `note_pkg` holds:
  - the code constants CODE_REST, CODE_K1, CODE_K2 and CODE_K0;
  - the state enum;
  - the slot width (2).
- The play logic imports `note_pkg` too.
- Sub-module `key_edge_sync`: 3-lane synchroniser plus falling-edge detector. Outputs a one-cycle `press[2:0]`, active-high.

## Test plan
All scenarios use SLOTS=4, BEAT_CYCLES=8.

- **Reset:** assert `reset_b`=0 mid-RECORD → all outputs 0 immediately, state IDLE.
- **Basic session:** `start`; press KEY[1] in slot 0 and KEY[2] in slot 2 → `chart`=8'h21, `beat` pulses 4 times, `done` one cycle at 32 cycles after `start`.
- **Simultaneous keys:** KEY[1] and KEY[0] fall in the same cycle in slot 1 → slot 1 = 01, `chart`=8'h04.
- **Two presses in one slot:** KEY[2] then KEY[0] in slot 3 → slot 3 = 10, `chart`=8'h80.
- **Held key:** KEY[0] held low from slot 0 through slot 2 → `chart`=8'h03 only.
- **Abort:** presses in slots 0 and 1, `abort` in slot 2 → IDLE, `chart` retains slots 0–1, slot 2 = 00, `done` never asserted.
- **Overdub:** with `NOTE_CHART_OVERDUB_EN` defined, a second session with a single KEY[2] press in slot 3 → previous slots 0–2 retained.
